// File: rtl/imm_inst_encoder.sv
// Packs RISC-V R/I/S/B/U/J fields into a 32-bit word, flagging unencodable requests (NOP + err).
// Two-stage pipeline, 2-cycle latency; valid/ready backpressure stalls both stages in place.
module imm_inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic             r_s1_vld;
  logic [2:0]       r_s1_fmt;
  logic [6:0]       r_s1_op;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [6:0]       r_s1_f7;
  logic [31:0]      r_s1_imm;
  logic             r_s1_err;

  logic             r_s2_vld;
  logic [31:0]      r_s2_inst;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_imm_ok;
  logic [31:0]      w_pack;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  assign in_ready  = rst_n && w_s1_adv;
  assign out_valid = r_s2_vld;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;
  assign err_cnt   = r_err_cnt;

  // Range checks are sign-extension tests on the bits above each field's width.
  always_comb begin
    w_imm_ok = 1'b1;
    case (in_fmt)
      FMT_R:        w_imm_ok = 1'b1;
      FMT_I, FMT_S: w_imm_ok = (in_imm[31:11] == {21{in_imm[11]}});
      FMT_B:        w_imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
      FMT_U:        w_imm_ok = (in_imm[11:0] == 12'h000);
      FMT_J:        w_imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
      default:      w_imm_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_pack = NOP_INST;
    case (r_s1_fmt)
      FMT_R: w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      FMT_I: w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      FMT_S: w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
      FMT_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                       r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
      FMT_U: w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
      FMT_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                       r_s1_rd, r_s1_op};
      default: w_pack = NOP_INST;
    endcase
    if (r_s1_err) w_pack = NOP_INST;
  end

  // S1 payload needs no reset: it is only observed through r_s1_vld.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1_fmt <= in_fmt;
      r_s1_op  <= in_opcode;
      r_s1_rd  <= in_rd;
      r_s1_rs1 <= in_rs1;
      r_s1_rs2 <= in_rs2;
      r_s1_f3  <= in_funct3;
      r_s1_f7  <= in_funct7;
      r_s1_imm <= in_imm;
      r_s1_err <= !w_imm_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_inst <= 32'h0;
      r_s2_err  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_s1_adv) r_s1_vld <= in_valid;
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_inst <= w_pack;
          r_s2_err  <= r_s1_err;
        end
      end
      if (r_s2_vld && out_ready && r_s2_err && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Scoreboard bench: the driver pushes model results on acceptance, the monitor pops on output handshakes.
module tb_imm_inst_encoder;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_ready;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_inst, out_inst2;
  logic        out_err, out_err2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;
  int   m_cnt16 = 0;
  int   m_cnt2 = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  imm_inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  imm_inst_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_err(out_err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Take n bits of v starting at bit lo and place them at bit pos.
  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n, input int pos);
    logic [31:0] mask;
    mask = (32'h1 << n) - 32'h1;
    return ((v >> lo) & mask) << pos;
  endfunction

  function automatic exp_t model(input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    int          s;
    bit          ok;
    logic [31:0] w;
    exp_t        e;
    s  = $signed(imm);
    ok = 1'b1;
    w  = fld(32'(op), 0, 7, 0);
    case (fmt)
      3'd0: w |= fld(32'(f7), 0, 7, 25) | fld(32'(rs2), 0, 5, 20) | fld(32'(rs1), 0, 5, 15)
               | fld(32'(f3), 0, 3, 12) | fld(32'(rd), 0, 5, 7);
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w |= fld(imm, 0, 12, 20) | fld(32'(rs1), 0, 5, 15) | fld(32'(f3), 0, 3, 12)
           | fld(32'(rd), 0, 5, 7);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w |= fld(imm, 5, 7, 25) | fld(32'(rs2), 0, 5, 20) | fld(32'(rs1), 0, 5, 15)
           | fld(32'(f3), 0, 3, 12) | fld(imm, 0, 5, 7);
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w |= fld(imm, 12, 1, 31) | fld(imm, 5, 6, 25) | fld(32'(rs2), 0, 5, 20)
           | fld(32'(rs1), 0, 5, 15) | fld(32'(f3), 0, 3, 12) | fld(imm, 1, 4, 8)
           | fld(imm, 11, 1, 7);
      end
      3'd4: begin
        ok = ((imm % 32'd4096) == 32'd0);
        w |= fld(imm, 12, 20, 12) | fld(32'(rd), 0, 5, 7);
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w |= fld(imm, 20, 1, 31) | fld(imm, 1, 10, 21) | fld(imm, 11, 1, 20)
           | fld(imm, 12, 8, 12) | fld(32'(rd), 0, 5, 7);
      end
      default: ok = 1'b0;
    endcase
    e.err  = !ok;
    e.inst = ok ? w : 32'h00000013;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (acc) begin
      chk("in_ready_sat_inst", 32'(in_ready2), 32'd1);
      exp_q.push_back(model(fmt, op, rd, rs1, rs2, f3, f7, imm));
      accepted++;
      @(posedge clk); #1;
    end else begin
      chk("accept_timeout", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string name, input logic [2:0] fmt, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
    int w;
    send(fmt, op, rd, rs1, rs2, 3'd0, 7'd0, imm, w);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_inst"}, out_inst, exp_inst);
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_imm(input logic [31:0] r2, input logic [31:0] r3);
    case (r2[5:3])
      3'd0, 3'd1: return r3;
      3'd2:       return {{20{r3[12]}}, r3[11:0]};
      3'd3:       return {r3[31:12], 12'h000};
      3'd4:       return {{11{r3[20]}}, r3[20:0]};
      default: begin
        case (r3[3:0])
          4'd0:  return 32'h000007FF;
          4'd1:  return 32'h00000800;
          4'd2:  return 32'hFFFFF800;
          4'd3:  return 32'hFFFFF7FF;
          4'd4:  return 32'h00000FFE;
          4'd5:  return 32'h00001000;
          4'd6:  return 32'hFFFFF000;
          4'd7:  return 32'hFFFFEFFE;
          4'd8:  return 32'h000FFFFE;
          4'd9:  return 32'h00100000;
          4'd10: return 32'hFFF00000;
          4'd11: return 32'hFFEFFFFE;
          4'd12: return 32'h00000FFF;
          default: return 32'h00000000;
        endcase
      end
    endcase
  endfunction

  // Monitor: hold-stability, ordering and saturating error count.
  initial begin
    exp_t        e;
    bit          held_vld;
    logic [31:0] held_inst;
    logic        held_err;
    held_vld = 1'b0;
    held_inst = 32'h0;
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt16));
        chk("err_cnt_sat", 32'(err_cnt2), 32'(m_cnt2));
        if (held_vld) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_inst", out_inst, held_inst);
          chk("hold_err", 32'(out_err), 32'(held_err));
        end
        if (out_valid) begin
          chk("output_expected", 32'(exp_q.size() != 0), 32'd1);
          if (out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_inst", out_inst, e.inst);
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("sat_out_valid", 32'(out_valid2), 32'd1);
            chk("sat_out_inst", out_inst2, e.inst);
            if (e.err) begin
              if (m_cnt16 < 65535) m_cnt16++;
              if (m_cnt2 < 3) m_cnt2++;
            end
          end
        end
        held_vld  = out_valid && !out_ready;
        held_inst = out_inst;
        held_err  = out_err;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          acc0;
    logic [31:0] r1, r2, r3;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;

    // Reset state, in_ready held low while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First request accepted immediately; exact 2-cycle latency.
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w);
    chk("first_accept_wait", 32'(w), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_inst", out_inst, 32'hFFF00093);
    chk("addi_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;

    send_chk("beq", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0);
    send_chk("jal", 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b0);

    // Unencodable requests.
    send_chk("b_odd", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00000013, 1'b1);
    send_chk("i_2048", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h00000013, 1'b1);
    send_chk("fmt7", 3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 32'd0, 32'h00000013, 1'b1);
    drain();
    chk("err_cnt_three", 32'(err_cnt), 32'd3);
    chk("err_cnt_sat_three", 32'(err_cnt2), 32'd3);

    // Backpressure: only two fit while the output is stalled.
    out_ready = 1'b0;
    acc0 = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(3'd1, 7'b0010011, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i * 100), w);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_accepted_two", 32'(accepted - acc0), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_four", 32'(accepted - acc0), 32'd4);

    // Reset with both stages full: nothing in flight may emerge.
    out_ready = 1'b0;
    send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, w);
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd5000, w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_cnt16 = 0;
    m_cnt2 = 0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
    chk("no_stale_word", 32'(out_valid), 32'd0);

    // Saturation of the narrow counter: preload to 2, then five more errors.
    for (int i = 0; i < 2; i++) send(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, w);
    drain();
    chk("sat_preload", 32'(err_cnt2), 32'd2);
    for (int i = 0; i < 5; i++) send(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, w);
    drain();
    chk("sat_capped", 32'(err_cnt2), 32'd3);
    chk("wide_cnt_seven", 32'(err_cnt), 32'd7);
    idle(3);
    chk("sat_holds", 32'(err_cnt2), 32'd3);

    // Randomized traffic with random output stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          r1 = $urandom;
          r2 = $urandom;
          r3 = $urandom;
          send(r2[2:0], r1[6:0], r1[11:7], r1[16:12], r1[21:17], r1[24:22], r1[31:25],
               pick_imm(r2, r3), w);
          if (r2[9:8] == 2'd0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
